// File: rtl/ibex_cosim_pkg.sv
// ibex_cosim_pkg
//   Shared types for the Ibex co-simulation data-side tracker.
//   dside_req_t    : one granted dmem request held until its response arrives.
//   dside_access_t : one completed access record handed to the checker.
package ibex_cosim_pkg;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        mis_first;
        logic        mis_second;
    } dside_req_t;

    typedef struct packed {
        logic        store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        err;
        logic        mis_first;
        logic        mis_second;
    } dside_access_t;

endpackage

// File: rtl/ibex_dside_req_fifo.sv
// ibex_dside_req_fifo
//   Synchronous FIFO of dside_req_t holding granted requests awaiting response.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     push_i, data_i  write request and entry
//     pop_i           retire head entry (ignored when empty)
//     head_o          current head entry
//     full_o, empty_o occupancy flags
//     count_o         number of stored entries, 0..Depth
//   A push while full is accepted only if a pop happens in the same cycle.
module ibex_dside_req_fifo
    import ibex_cosim_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  dside_req_t                 data_i,
    input  logic                       pop_i,
    output dside_req_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    dside_req_t            mem_q [Depth];
    dside_req_t            mem_d [Depth];
    logic      [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic      [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic      [CntW-1:0]  count_q, count_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            // Depth is a power of two, so natural overflow wraps modulo Depth.
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ibex_dside_access_tracker.sv
// ibex_dside_access_tracker
//   Pairs granted Ibex dmem requests with their in-order responses and emits one
//   registered access record per response; flags protocol violations (sticky).
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     dmem_*_i                      data-side bus request/response signals
//     mis_first_i, mis_second_i     LSU misaligned-access halves
//     acc_valid_o, acc_o            completed record, valid for one cycle
//     outstanding_o                 requests granted but not yet answered
//     protocol_err_o                sticky: response with nothing outstanding, or overflow
//   Optional: define DSIDE_TRK_STATS_EN to add num_loads_o/num_stores_o/num_errs_o.
module ibex_dside_access_tracker
    import ibex_cosim_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       dmem_req_i,
    input  logic                       dmem_gnt_i,
    input  logic                       dmem_we_i,
    input  logic [31:0]                dmem_addr_i,
    input  logic [3:0]                 dmem_be_i,
    input  logic [31:0]                dmem_wdata_i,
    input  logic                       mis_first_i,
    input  logic                       mis_second_i,
    input  logic                       dmem_rvalid_i,
    input  logic [31:0]                dmem_rdata_i,
    input  logic                       dmem_err_i,
    output logic                       acc_valid_o,
    output dside_access_t              acc_o,
    output logic [$clog2(Depth+1)-1:0] outstanding_o,
`ifdef DSIDE_TRK_STATS_EN
    output logic [CntW-1:0]            num_loads_o,
    output logic [CntW-1:0]            num_stores_o,
    output logic [CntW-1:0]            num_errs_o,
`endif
    output logic                       protocol_err_o
);

    dside_req_t    push_entry, head;
    logic          push, pop, full, empty;
    logic          acc_valid_q, acc_valid_d;
    dside_access_t acc_q, acc_d;
    logic          perr_q, perr_d;

    assign push = dmem_req_i & dmem_gnt_i;
    assign pop  = dmem_rvalid_i;

    assign push_entry = '{
        we:         dmem_we_i,
        addr:       dmem_addr_i,
        be:         dmem_be_i,
        wdata:      dmem_wdata_i,
        mis_first:  mis_first_i,
        mis_second: mis_second_i
    };

    ibex_dside_req_fifo #(
        .Depth (Depth)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    always_comb begin
        acc_valid_d = 1'b0;
        acc_d       = acc_q;
        perr_d      = perr_q;
        if (pop && !empty) begin
            acc_valid_d      = 1'b1;
            acc_d.store      = head.we;
            acc_d.addr       = head.addr;
            acc_d.data       = head.we ? head.wdata : dmem_rdata_i;
            acc_d.be         = head.be;
            acc_d.err        = dmem_err_i;
            acc_d.mis_first  = head.mis_first;
            acc_d.mis_second = head.mis_second;
        end
        // A response can never answer a same-cycle grant, so only prior state matters.
        if (pop && empty) begin
            perr_d = 1'b1;
        end
        // Overflow: grant while full with no freeing pop; the FIFO drops the entry.
        if (push && full && !pop) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_valid_q <= 1'b0;
            acc_q       <= '0;
            perr_q      <= 1'b0;
        end else begin
            acc_valid_q <= acc_valid_d;
            acc_q       <= acc_d;
            perr_q      <= perr_d;
        end
    end

    assign acc_valid_o    = acc_valid_q;
    assign acc_o          = acc_q;
    assign protocol_err_o = perr_q;

`ifdef DSIDE_TRK_STATS_EN
    logic [CntW-1:0] loads_q, loads_d;
    logic [CntW-1:0] stores_q, stores_d;
    logic [CntW-1:0] errs_q, errs_d;

    // Counters advance alongside the record register so they line up with acc_valid_o.
    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        errs_d   = errs_q;
        if (acc_valid_d) begin
            if (acc_d.store) begin
                stores_d = stores_q + CntW'(1);
            end else begin
                loads_d = loads_q + CntW'(1);
            end
            if (acc_d.err) begin
                errs_d = errs_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            errs_q   <= errs_d;
        end
    end

    assign num_loads_o  = loads_q;
    assign num_stores_o = stores_q;
    assign num_errs_o   = errs_q;
`endif

endmodule

// File: tb/tb_ibex_dside_access_tracker.sv
// Bench for ibex_dside_access_tracker (default build, Depth=4).
module tb_ibex_dside_access_tracker;
    import ibex_cosim_pkg::*;

    localparam int unsigned Depth = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          dmem_req_i, dmem_gnt_i, dmem_we_i;
    logic [31:0]   dmem_addr_i, dmem_wdata_i, dmem_rdata_i;
    logic [3:0]    dmem_be_i;
    logic          mis_first_i, mis_second_i;
    logic          dmem_rvalid_i, dmem_err_i;
    logic          acc_valid_o;
    dside_access_t acc_o;
    logic [2:0]    outstanding_o;
    logic          protocol_err_o;

    ibex_dside_access_tracker #(
        .Depth (Depth),
        .CntW  (32)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .dmem_req_i     (dmem_req_i),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_we_i      (dmem_we_i),
        .dmem_addr_i    (dmem_addr_i),
        .dmem_be_i      (dmem_be_i),
        .dmem_wdata_i   (dmem_wdata_i),
        .mis_first_i    (mis_first_i),
        .mis_second_i   (mis_second_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_err_i     (dmem_err_i),
        .acc_valid_o    (acc_valid_o),
        .acc_o          (acc_o),
        .outstanding_o  (outstanding_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        mf;
        logic        ms;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        exp_valid;
        int          exp_out;
        logic        exp_perr;
    } vec_t;

    vec_t          vecs[$];
    dside_req_t    mq[$];
    dside_access_t exp_q[$];
    logic          m_err;
    int            pass_cnt = 0;
    int            chk_cnt  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                                logic [31:0] wdata, logic mf, logic ms, logic rv,
                                logic [31:0] rdata, logic err, logic ev, int eo, logic ep);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
        v.mf = mf; v.ms = ms; v.rvalid = rv; v.rdata = rdata; v.err = err;
        v.exp_valid = ev; v.exp_out = eo; v.exp_perr = ep;
        return v;
    endfunction

    function automatic vec_t gnt(logic we, logic [31:0] addr, int eo, logic ep);
        return mk(1, we, addr, 4'hF, addr ^ 32'h5A5A_0000, 0, 0, 0, 0, 0, 0, eo, ep);
    endfunction

    function automatic vec_t rsp(logic [31:0] rdata, logic err, logic ev, int eo, logic ep);
        return mk(0, 0, 0, 0, 0, 0, 0, 1, rdata, err, ev, eo, ep);
    endfunction

    function automatic vec_t idle(int eo, logic ep);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, ep);
    endfunction

    // One clock of stimulus; the bench model predicts the outcome independently.
    task automatic drive_cycle(input vec_t v, input bit tbl);
        logic          m_pop, m_push, exp_valid;
        dside_access_t r;
        dside_req_t    e;
        dmem_req_i    = v.req;
        dmem_gnt_i    = v.req;
        dmem_we_i     = v.we;
        dmem_addr_i   = v.addr;
        dmem_be_i     = v.be;
        dmem_wdata_i  = v.wdata;
        mis_first_i   = v.mf;
        mis_second_i  = v.ms;
        dmem_rvalid_i = v.rvalid;
        dmem_rdata_i  = v.rdata;
        dmem_err_i    = v.err;

        m_pop  = v.rvalid && (mq.size() > 0);
        m_push = v.req && ((mq.size() < Depth) || m_pop);
        if (v.rvalid && mq.size() == 0) m_err = 1'b1;
        if (v.req && mq.size() == Depth && !v.rvalid) m_err = 1'b1;
        if (m_pop) begin
            e = mq.pop_front();
            r.store = e.we; r.addr = e.addr; r.be = e.be;
            r.data = e.we ? e.wdata : v.rdata;
            r.err = v.err; r.mis_first = e.mis_first; r.mis_second = e.mis_second;
            exp_q.push_back(r);
        end
        if (m_push) begin
            e.we = v.we; e.addr = v.addr; e.be = v.be; e.wdata = v.wdata;
            e.mis_first = v.mf; e.mis_second = v.ms;
            mq.push_back(e);
        end
        exp_valid = tbl ? v.exp_valid : m_pop;

        @(posedge clk_i);
        #1;
        chk("acc_valid", 128'(acc_valid_o), 128'(exp_valid));
        chk("outstanding", 128'(outstanding_o), tbl ? 128'(v.exp_out) : 128'(mq.size()));
        chk("protocol_err", 128'(protocol_err_o), tbl ? 128'(v.exp_perr) : 128'(m_err));
        if (acc_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("record_unexpected", 128'(acc_o), 128'(0) - 128'(1));
            end else begin
                r = exp_q.pop_front();
                chk("record", 128'(acc_o), 128'(r));
            end
        end
    endtask

    initial begin
        vec_t v;
        rst_ni = 1'b0;
        m_err  = 1'b0;
        v = idle(0, 0);
        dmem_req_i = 0; dmem_gnt_i = 0; dmem_we_i = 0; dmem_addr_i = 0; dmem_be_i = 0;
        dmem_wdata_i = 0; mis_first_i = 0; mis_second_i = 0; dmem_rvalid_i = 0;
        dmem_rdata_i = 0; dmem_err_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_acc_valid", 128'(acc_valid_o), 128'(0));
        chk("reset_acc", 128'(acc_o), 128'(0));
        chk("reset_outstanding", 128'(outstanding_o), 128'(0));
        chk("reset_perr", 128'(protocol_err_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Directed table: inputs for one cycle, expected outputs just after that edge.
        vecs.push_back(gnt(0, 32'h1000, 1, 0));
        vecs.push_back(idle(1, 0));
        vecs.push_back(rsp(32'hDEAD_BEEF, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 32'h2004, 4'hC, 32'h1234_0000, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(rsp(32'hFFFF_FFFF, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0100, 4'hF, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h0104, 4'h3, 0, 0, 1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(gnt(1, 32'h0108, 3, 0));
        vecs.push_back(gnt(0, 32'h010C, 4, 0));
        vecs.push_back(mk(1, 0, 32'h0200, 4'hF, 0, 0, 0, 1, 32'hA0, 0, 1, 4, 0));
        vecs.push_back(rsp(32'hB1, 0, 1, 3, 0));
        vecs.push_back(rsp(32'hB2, 1, 1, 2, 0));
        vecs.push_back(rsp(32'hB3, 0, 1, 1, 0));
        vecs.push_back(rsp(32'hB4, 0, 1, 0, 0));
        vecs.push_back(idle(0, 0));
        vecs.push_back(rsp(32'hC0, 0, 0, 0, 1));
        vecs.push_back(idle(0, 1));
        vecs.push_back(gnt(0, 32'h3000, 1, 1));
        vecs.push_back(rsp(32'hC1, 0, 1, 0, 1));
        vecs.push_back(gnt(0, 32'h4000, 1, 1));
        vecs.push_back(gnt(1, 32'h4004, 2, 1));
        vecs.push_back(gnt(0, 32'h4008, 3, 1));
        vecs.push_back(gnt(0, 32'h400C, 4, 1));
        vecs.push_back(gnt(0, 32'h4010, 4, 1));
        vecs.push_back(rsp(32'hD0, 0, 1, 3, 1));
        vecs.push_back(rsp(32'hD1, 0, 1, 2, 1));
        vecs.push_back(rsp(32'hD2, 0, 1, 1, 1));
        vecs.push_back(rsp(32'hD3, 1, 1, 0, 1));
        vecs.push_back(idle(0, 1));
        for (int i = 0; i < vecs.size(); i++) drive_cycle(vecs[i], 1'b1);

        // Reset with three requests in flight: everything is discarded.
        drive_cycle(gnt(0, 32'h5000, 0, 0), 1'b0);
        drive_cycle(gnt(1, 32'h5004, 0, 0), 1'b0);
        drive_cycle(gnt(0, 32'h5008, 0, 0), 1'b0);
        chk("pre_reset_outstanding", 128'(outstanding_o), 128'(3));
        dmem_req_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
        rst_ni = 1'b0;
        #1;
        chk("midreset_outstanding", 128'(outstanding_o), 128'(0));
        chk("midreset_perr", 128'(protocol_err_o), 128'(0));
        chk("midreset_acc_valid", 128'(acc_valid_o), 128'(0));
        mq.delete();
        exp_q.delete();
        m_err = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(idle(0, 0), 1'b0);
        drive_cycle(gnt(0, 32'h6000, 0, 0), 1'b0);
        drive_cycle(rsp(32'h6666_0000, 0, 0, 0, 0), 1'b0);

        // Pseudo-random traffic checked against the bench model.
        for (int i = 0; i < 300; i++) begin
            logic rv;
            rv = ($urandom_range(0, 2) == 0) && ((mq.size() > 0) || ($urandom_range(0, 19) == 0));
            v = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                   4'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 1), rv,
                   $urandom, ($urandom_range(0, 7) == 0), 0, 0, 0);
            drive_cycle(v, 1'b0);
        end
        while (mq.size() > 0) drive_cycle(rsp($urandom, 0, 0, 0, 0), 1'b0);
        drive_cycle(idle(0, 0), 1'b0);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
